// File: rtl/store_retire_buffer.sv
// Post-retirement store buffer: accepts up to three retired stores per cycle,
// drains one per cycle to the data cache and forwards held bytes to two load ports.
module store_retire_buffer #(
  parameter int DEPTH = 8,
  parameter int XLEN  = 32
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic [2:0]                   rt_valid,
  input  logic [2:0][XLEN-1:0]         rt_addr,
  input  logic [2:0][XLEN-1:0]         rt_data,
  input  logic [2:0][3:0]              rt_usebytes,
  output logic [$clog2(DEPTH):0]       free_slots,
  output logic                         cache_wr_valid,
  output logic [XLEN-1:0]              cache_wr_addr,
  output logic [XLEN-1:0]              cache_wr_data,
  output logic [3:0]                   cache_wr_usebytes,
  input  logic                         cache_wr_ready,
  input  logic [1:0][XLEN-1:0]         ld_addr,
  output logic [1:0][XLEN-1:0]         ld_fwd_data,
  output logic [1:0][3:0]              ld_fwd_bytes,
  output logic                         empty,
  output logic                         overflow_err
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int AW = XLEN - 2;

  logic [AW-1:0]   mem_addr [DEPTH];
  logic [XLEN-1:0] mem_data [DEPTH];
  logic [3:0]      mem_ube  [DEPTH];

  logic [PW-1:0]      head, tail;
  logic [CW-1:0]      count, count_next, push_cnt;
  logic [2:0]         wr_en;
  logic [2:0][PW-1:0] wr_idx;
  logic               ovf_now, pop, has_head;
  logic [PW-1:0]      fwd_idx;

  // Word-aligned addressing: the low address bits never take part in any match.
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^{rt_addr[0][1:0], rt_addr[1][1:0], rt_addr[2][1:0],
                              ld_addr[0][1:0], ld_addr[1][1:0]};

  // Cache handshake: the head entry is offered while cache_wr_valid is high and is
  // consumed on any cycle where cache_wr_valid && cache_wr_ready; the offered fields
  // hold steady until that happens. No write is offered during reset.
  assign has_head          = (count != '0);
  assign cache_wr_valid    = has_head && !reset;
  assign cache_wr_addr     = has_head ? {mem_addr[head], 2'b00} : '0;
  assign cache_wr_data     = has_head ? mem_data[head] : '0;
  assign cache_wr_usebytes = has_head ? mem_ube[head] : '0;
  assign pop               = cache_wr_valid && cache_wr_ready;

  // Compact valid slots onto consecutive entries; capacity is the registered free
  // count, so a pop in the same cycle never makes room for an extra store.
  always_comb begin
    push_cnt = '0;
    ovf_now  = 1'b0;
    wr_en    = '0;
    wr_idx   = '0;
    for (int s = 0; s < 3; s++) begin
      if (rt_valid[s]) begin
        if (push_cnt < free_slots) begin
          wr_en[s]  = 1'b1;
          wr_idx[s] = tail + push_cnt[PW-1:0];
          push_cnt  = push_cnt + CW'(1);
        end else begin
          ovf_now = 1'b1;
        end
      end
    end
  end

  assign count_next = count + push_cnt - CW'(pop);

  always_ff @(posedge clock) begin
    if (reset) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      free_slots   <= CW'(DEPTH);
      empty        <= 1'b1;
      overflow_err <= 1'b0;
    end else begin
      head         <= head + PW'(pop);
      tail         <= tail + push_cnt[PW-1:0];
      count        <= count_next;
      free_slots   <= CW'(DEPTH) - count_next;
      empty        <= (count_next == '0);
      overflow_err <= overflow_err | ovf_now;
    end
  end

  always_ff @(posedge clock) begin
    for (int s = 0; s < 3; s++) begin
      if (wr_en[s]) begin
        mem_addr[wr_idx[s]] <= rt_addr[s][XLEN-1:2];
        mem_data[wr_idx[s]] <= rt_data[s];
        mem_ube[wr_idx[s]]  <= rt_usebytes[s];
      end
    end
  end

  // Walk entries oldest to youngest so the youngest matching byte wins.
  always_comb begin
    ld_fwd_data  = '0;
    ld_fwd_bytes = '0;
    fwd_idx      = '0;
    for (int p = 0; p < 2; p++) begin
      for (int i = 0; i < DEPTH; i++) begin
        fwd_idx = head + PW'(i);
        if ((CW'(i) < count) && (mem_addr[fwd_idx] == ld_addr[p][XLEN-1:2])) begin
          for (int b = 0; b < 4; b++) begin
            if (mem_ube[fwd_idx][b]) begin
              ld_fwd_data[p][8*b +: 8] = mem_data[fwd_idx][8*b +: 8];
              ld_fwd_bytes[p][b]       = 1'b1;
            end
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_store_retire_buffer.sv
// Self-checking bench for store_retire_buffer: scenario tasks with inline checks and
// a drain scoreboard fed at retire time.
module tb_store_retire_buffer;
  localparam int DEPTH = 8;
  localparam int XLEN  = 32;

  logic                 clock = 1'b0;
  logic                 reset;
  logic [2:0]           rt_valid;
  logic [2:0][XLEN-1:0] rt_addr, rt_data;
  logic [2:0][3:0]      rt_usebytes;
  logic [3:0]           free_slots;
  logic                 cache_wr_valid, cache_wr_ready;
  logic [XLEN-1:0]      cache_wr_addr, cache_wr_data;
  logic [3:0]           cache_wr_usebytes;
  logic [1:0][XLEN-1:0] ld_addr, ld_fwd_data;
  logic [1:0][3:0]      ld_fwd_bytes;
  logic                 empty, overflow_err;

  int         n_cmp = 0;
  int         n_err = 0;
  logic [67:0] exp_q[$];
  logic [67:0] mon_exp;
  logic        exp_ovf = 1'b0;

  store_retire_buffer #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clock(clock), .reset(reset),
    .rt_valid(rt_valid), .rt_addr(rt_addr), .rt_data(rt_data), .rt_usebytes(rt_usebytes),
    .free_slots(free_slots),
    .cache_wr_valid(cache_wr_valid), .cache_wr_addr(cache_wr_addr),
    .cache_wr_data(cache_wr_data), .cache_wr_usebytes(cache_wr_usebytes),
    .cache_wr_ready(cache_wr_ready),
    .ld_addr(ld_addr), .ld_fwd_data(ld_fwd_data), .ld_fwd_bytes(ld_fwd_bytes),
    .empty(empty), .overflow_err(overflow_err)
  );

  // clock / reset
  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  // scoreboard: every accepted write is compared against the oldest expected store
  always @(negedge clock) begin
    if (!reset && cache_wr_valid && cache_wr_ready) begin
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL drain_extra: got write addr=%h, expected none", cache_wr_addr);
      end else begin
        mon_exp = exp_q.pop_front();
        if ({cache_wr_addr, cache_wr_data, cache_wr_usebytes} !== mon_exp) begin
          n_err++;
          $display("FAIL drain_order: got %h/%h/%h expected %h/%h/%h",
                   cache_wr_addr, cache_wr_data, cache_wr_usebytes,
                   mon_exp[67:36], mon_exp[35:4], mon_exp[3:0]);
        end
      end
    end
  end

  // driver tasks: all run at posedge+1
  task automatic drive_rt(input logic [2:0] v,
                          input logic [31:0] a0, input logic [31:0] d0, input logic [3:0] u0,
                          input logic [31:0] a1, input logic [31:0] d1, input logic [3:0] u1,
                          input logic [31:0] a2, input logic [31:0] d2, input logic [3:0] u2);
    logic [31:0] aa[3];
    logic [31:0] dd[3];
    logic [3:0]  uu[3];
    int free, k;
    aa = '{a0, a1, a2};
    dd = '{d0, d1, d2};
    uu = '{u0, u1, u2};
    free = DEPTH - exp_q.size();
    k = 0;
    for (int s = 0; s < 3; s++) begin
      rt_addr[s]     = aa[s];
      rt_data[s]     = dd[s];
      rt_usebytes[s] = uu[s];
      if (v[s]) begin
        if (k < free) begin
          exp_q.push_back({aa[s] & 32'hFFFF_FFFC, dd[s], uu[s]});
          k++;
        end else begin
          exp_ovf = 1'b1;
        end
      end
    end
    rt_valid = v;
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
    rt_valid = '0;
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_q.size() != 0 && t < 64) begin
      cyc();
      t++;
    end
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d stores left, expected 0", exp_q.size());
      exp_q.delete();
    end
    cyc();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cache_wr_ready = 1'b0;
    rt_valid = '0; rt_addr = '0; rt_data = '0; rt_usebytes = '0; ld_addr = '0;
    repeat (2) @(posedge clock);
    #1;
    reset = 1'b0;
    n_cmp++; if (free_slots !== 4'd8) begin n_err++; $display("FAIL rst_free: got %0d expected 8", free_slots); end
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rst_empty: got %b expected 1", empty); end
    n_cmp++; if (cache_wr_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %b expected 0", cache_wr_valid); end
    n_cmp++; if (cache_wr_addr !== 32'h0) begin n_err++; $display("FAIL rst_addr: got %h expected 0", cache_wr_addr); end
    n_cmp++; if (cache_wr_data !== 32'h0) begin n_err++; $display("FAIL rst_data: got %h expected 0", cache_wr_data); end
    n_cmp++; if (cache_wr_usebytes !== 4'h0) begin n_err++; $display("FAIL rst_ube: got %h expected 0", cache_wr_usebytes); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL rst_ovf: got %b expected 0", overflow_err); end
  endtask

  task automatic test_basic_drain();
    cache_wr_ready = 1'b1;
    drive_rt(3'b111, 32'h100, 32'hAABBCCDD, 4'b1111, 32'h104, 32'h11, 4'b0001,
             32'h108, 32'h2200, 4'b0010);
    cyc();
    n_cmp++; if (free_slots !== 4'd5) begin n_err++; $display("FAIL basic_free: got %0d expected 5", free_slots); end
    n_cmp++; if (empty !== 1'b0) begin n_err++; $display("FAIL basic_empty: got %b expected 0", empty); end
    wait_drain();
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL basic_empty_end: got %b expected 1", empty); end
    n_cmp++; if (free_slots !== 4'd8) begin n_err++; $display("FAIL basic_free_end: got %0d expected 8", free_slots); end
  endtask

  task automatic test_overflow();
    logic [3:0] exp_free[3];
    exp_free = '{4'd8, 4'd5, 4'd2};
    cache_wr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_cmp++;
      if (free_slots !== exp_free[c]) begin
        n_err++; $display("FAIL ovf_free%0d: got %0d expected %0d", c, free_slots, exp_free[c]);
      end
      drive_rt(3'b111, 32'h300 + 32'(12*c), 32'h5000 + 32'(c), 4'hF,
               32'h304 + 32'(12*c), 32'h6000 + 32'(c), 4'hF,
               32'h308 + 32'(12*c), 32'h7000 + 32'(c), 4'hF);
      cyc();
      n_cmp++;
      if ({cache_wr_valid, cache_wr_addr, cache_wr_data} !== {1'b1, 32'h300, 32'h5000}) begin
        n_err++; $display("FAIL ovf_head%0d: got %b/%h/%h expected 1/300/5000",
                          c, cache_wr_valid, cache_wr_addr, cache_wr_data);
      end
    end
    n_cmp++; if (free_slots !== 4'd0) begin n_err++; $display("FAIL ovf_full: got %0d expected 0", free_slots); end
    n_cmp++; if (overflow_err !== exp_ovf) begin n_err++; $display("FAIL ovf_flag: got %b expected %b", overflow_err, exp_ovf); end
    cache_wr_ready = 1'b1;
    wait_drain();
    n_cmp++; if (overflow_err !== 1'b1) begin n_err++; $display("FAIL ovf_sticky: got %b expected 1", overflow_err); end
  endtask

  task automatic test_forward();
    cache_wr_ready = 1'b0;
    ld_addr[0] = 32'h202;
    ld_addr[1] = 32'h204;
    drive_rt(3'b011, 32'h200, 32'h000000EE, 4'b0001, 32'h200, 32'h0000FF00, 4'b0011,
             32'h0, 32'h0, 4'h0);
    #1;
    n_cmp++; if (ld_fwd_bytes[0] !== 4'b0000) begin n_err++; $display("FAIL fwd_sameCycle: got %b expected 0000", ld_fwd_bytes[0]); end
    cyc();
    n_cmp++; if (ld_fwd_bytes[0] !== 4'b0011) begin n_err++; $display("FAIL fwd_bytes: got %b expected 0011", ld_fwd_bytes[0]); end
    n_cmp++; if (ld_fwd_data[0] !== 32'h0000FF00) begin n_err++; $display("FAIL fwd_data: got %h expected 0000ff00", ld_fwd_data[0]); end
    n_cmp++; if ({ld_fwd_bytes[1], ld_fwd_data[1]} !== 36'h0) begin n_err++; $display("FAIL fwd_miss: got %b/%h expected 0/0", ld_fwd_bytes[1], ld_fwd_data[1]); end
    ld_addr[1] = 32'h200;
    cache_wr_ready = 1'b1;
    #1;
    n_cmp++; if (ld_fwd_bytes[1] !== 4'b0011) begin n_err++; $display("FAIL fwd_popping: got %b expected 0011", ld_fwd_bytes[1]); end
    wait_drain();
    n_cmp++; if (ld_fwd_bytes[0] !== 4'b0000) begin n_err++; $display("FAIL fwd_drained: got %b expected 0000", ld_fwd_bytes[0]); end
  endtask

  task automatic test_wrap();
    cache_wr_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      drive_rt(3'b111, 32'h400 + 32'(12*c), $urandom(), 4'hF, 32'h404 + 32'(12*c), $urandom(), 4'hF,
               32'h408 + 32'(12*c), $urandom(), 4'hF);
      cyc();
    end
    cache_wr_ready = 1'b1;
    wait_drain();
    cache_wr_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive_rt((c == 2) ? 3'b001 : 3'b111, 32'h480 + 32'(12*c), $urandom(), 4'(c + 1),
               32'h484 + 32'(12*c), $urandom(), 4'hF, 32'h488 + 32'(12*c), $urandom(), 4'hC);
      cyc();
    end
    n_cmp++; if (free_slots !== 4'd1) begin n_err++; $display("FAIL wrap_free7: got %0d expected 1", free_slots); end
    cache_wr_ready = 1'b1;
    drive_rt(3'b001, 32'h4F0, $urandom(), 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    cyc();
    n_cmp++; if (free_slots !== 4'd1) begin n_err++; $display("FAIL wrap_count: got %0d expected 1", free_slots); end
    wait_drain();
  endtask

  task automatic test_reset_mid();
    cache_wr_ready = 1'b0;
    drive_rt(3'b111, 32'h500, 32'h1, 4'hF, 32'h504, 32'h2, 4'hF, 32'h508, 32'h3, 4'hF);
    cyc();
    drive_rt(3'b001, 32'h50C, 32'h4, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    cyc();
    reset = 1'b1;
    exp_q.delete();
    exp_ovf = 1'b0;
    #1;
    n_cmp++; if (cache_wr_valid !== 1'b0) begin n_err++; $display("FAIL rmid_noWrite: got %b expected 0", cache_wr_valid); end
    @(posedge clock);
    #1;
    reset = 1'b0;
    ld_addr[0] = 32'h500;
    ld_addr[1] = 32'h50C;
    #1;
    n_cmp++; if (empty !== 1'b1) begin n_err++; $display("FAIL rmid_empty: got %b expected 1", empty); end
    n_cmp++; if (cache_wr_valid !== 1'b0) begin n_err++; $display("FAIL rmid_valid: got %b expected 0", cache_wr_valid); end
    n_cmp++; if (free_slots !== 4'd8) begin n_err++; $display("FAIL rmid_free: got %0d expected 8", free_slots); end
    n_cmp++; if (overflow_err !== 1'b0) begin n_err++; $display("FAIL rmid_ovf: got %b expected 0", overflow_err); end
    n_cmp++; if (ld_fwd_bytes !== 8'h00) begin n_err++; $display("FAIL rmid_fwd: got %h expected 00", ld_fwd_bytes); end
  endtask

  task automatic test_sparse();
    cache_wr_ready = 1'b0;
    cyc();
    drive_rt(3'b001, 32'h600, 32'hCAFE0001, 4'hF, 32'h0, 32'h0, 4'h0, 32'h0, 32'h0, 4'h0);
    cyc();
    drive_rt(3'b010, 32'h6F0, 32'hDEAD0000, 4'hF, 32'h605, 32'h12345678, 4'b1001,
             32'h6F8, 32'hBEEF0000, 4'hF);
    cyc();
    ld_addr[0] = 32'h604;
    ld_addr[1] = 32'h6F0;
    #1;
    n_cmp++; if (free_slots !== 4'd6) begin n_err++; $display("FAIL sparse_free: got %0d expected 6", free_slots); end
    n_cmp++; if ({ld_fwd_bytes[0], ld_fwd_data[0]} !== {4'b1001, 32'h12000078}) begin
      n_err++; $display("FAIL sparse_fwd: got %b/%h expected 1001/12000078", ld_fwd_bytes[0], ld_fwd_data[0]);
    end
    n_cmp++; if (ld_fwd_bytes[1] !== 4'b0000) begin n_err++; $display("FAIL sparse_skip: got %b expected 0000", ld_fwd_bytes[1]); end
    cache_wr_ready = 1'b1;
    wait_drain();
  endtask

  initial begin
    test_reset();
    test_basic_drain();
    test_overflow();
    test_forward();
    test_wrap();
    test_reset_mid();
    test_sparse();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
